// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: load-op encodings, forwarding bus
// widths and the outstanding-request counter width helper.
package mem_pkg;

    localparam logic [2:0] LOAD_OP_ALU = 3'd0;
    localparam logic [2:0] LOAD_OP_LW  = 3'd1;
    localparam logic [2:0] LOAD_OP_LH  = 3'd2;
    localparam logic [2:0] LOAD_OP_LB  = 3'd3;
    localparam logic [2:0] LOAD_OP_LWL = 3'd4;
    localparam logic [2:0] LOAD_OP_LWR = 3'd5;

    localparam int unsigned FWD_WE_W   = 4;
    localparam int unsigned FWD_DEST_W = 5;
    localparam int unsigned FWD_DATA_W = 32;

    function automatic int unsigned cnt_width(input int unsigned max_outst);
        return $clog2(max_outst + 1);
    endfunction

    // Ops 6/7 fall back to the ALU result, so only 1..5 read memory data.
    function automatic logic is_load_op(input logic [2:0] op);
        return (op >= LOAD_OP_LW) && (op <= LOAD_OP_LWR);
    endfunction

endpackage

// File: rtl/mem_resp_stage_if.sv
// Data-bus handshake between EX / the data bus and the MEM stage.
// master: EX request side plus bus response; slave: mem_resp_stage.
interface mem_resp_stage_if;
    import mem_pkg::*;

    logic                  es_req_fire;
    logic                  ms_can_issue;
    logic                  data_ok;
    logic [FWD_DATA_W-1:0] data_rdata;

    modport master (
        output es_req_fire,
        output data_ok,
        output data_rdata,
        input  ms_can_issue
    );

    modport slave (
        input  es_req_fire,
        input  data_ok,
        input  data_rdata,
        output ms_can_issue
    );

endinterface

// File: rtl/mem_resp_stage_load_align.sv
// Combinational load alignment / extension. lwl/lwr merge with rt only when
// MEM_LWLR_EN is defined; otherwise ops 4/5 decode as lw.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  load_op_i,
    input  logic        ext_i,
    input  logic [31:0] rt_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = data_i[7:0];
        case (offset_i)
            2'd0: byte_sel = data_i[7:0];
            2'd1: byte_sel = data_i[15:8];
            2'd2: byte_sel = data_i[23:16];
            2'd3: byte_sel = data_i[31:24];
            default: byte_sel = data_i[7:0];
        endcase
        half_sel = offset_i[1] ? data_i[31:16] : data_i[15:0];
    end

`ifdef MEM_LWLR_EN
    always_comb begin
        result_o = data_i;
        case (load_op_i)
            LOAD_OP_LH: result_o = {{16{ext_i & half_sel[15]}}, half_sel};
            LOAD_OP_LB: result_o = {{24{ext_i & byte_sel[7]}}, byte_sel};
            LOAD_OP_LWL: begin
                case (offset_i)
                    2'd0: result_o = {data_i[7:0],  rt_i[23:0]};
                    2'd1: result_o = {data_i[15:0], rt_i[15:0]};
                    2'd2: result_o = {data_i[23:0], rt_i[7:0]};
                    default: result_o = data_i;
                endcase
            end
            LOAD_OP_LWR: begin
                case (offset_i)
                    2'd1: result_o = {rt_i[31:24], data_i[31:8]};
                    2'd2: result_o = {rt_i[31:16], data_i[31:16]};
                    2'd3: result_o = {rt_i[31:8],  data_i[31:24]};
                    default: result_o = data_i;
                endcase
            end
            default: result_o = data_i;
        endcase
    end
`else
    logic unused_rt;
    assign unused_rt = ^rt_i;

    always_comb begin
        result_o = data_i;
        case (load_op_i)
            LOAD_OP_LH: result_o = {{16{ext_i & half_sel[15]}}, half_sel};
            LOAD_OP_LB: result_o = {{24{ext_i & byte_sel[7]}}, byte_sel};
            default:    result_o = data_i;
        endcase
    end
`endif

endmodule

// File: rtl/mem_resp_stage.sv
// MEM stage of the 5-stage MIPS core: tracks outstanding data requests, drops
// beats of flushed loads, buffers one beat under WB stall. Option: MEM_LWLR_EN.
module mem_resp_stage
    import mem_pkg::*;
#(
    parameter int unsigned MAX_OUTST = 2,
    parameter int unsigned SB_W      = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,

    input  logic                  es_valid,
    output logic                  ms_allowin,
    mem_resp_stage_if.slave       dbus,

    input  logic [31:0]           in_pc,
    input  logic [31:0]           in_alu_result,
    input  logic [31:0]           in_rt_value,
    input  logic [4:0]            in_dest,
    input  logic [3:0]            in_gr_we,
    input  logic [2:0]            in_load_op,
    input  logic                  in_load_ext,
    input  logic                  in_req_sent,
    input  logic                  in_ex,
    input  logic [SB_W-1:0]       in_sideband,

    input  logic                  ws_allowin,
    output logic                  ms_to_ws_valid,
    output logic [31:0]           out_pc,
    output logic [31:0]           out_result,
    output logic [4:0]            out_dest,
    output logic [3:0]            out_gr_we,
    output logic                  out_ex,
    output logic [SB_W-1:0]       out_sideband,

    output logic                  ms_ex_block,
    output logic                  fwd_valid,
    output logic [FWD_WE_W-1:0]   fwd_we,
    output logic [FWD_DEST_W-1:0] fwd_dest,
    output logic [FWD_DATA_W-1:0] fwd_result,
    output logic                  fwd_data_ready
);

    localparam int unsigned      CNT_W   = cnt_width(MAX_OUTST);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

    logic             ms_valid_q, ms_valid_d;
    logic [31:0]      pc_q, alu_q, rt_q;
    logic [4:0]       dest_q;
    logic [3:0]       gr_we_q;
    logic [2:0]       load_op_q;
    logic             ext_q, req_sent_q, ex_q;
    logic [SB_W-1:0]  sb_q;

    logic [CNT_W-1:0] pend_q, pend_d;
    logic [CNT_W-1:0] cancel_q, cancel_d;
    logic             buf_valid_q, buf_valid_d;
    logic [31:0]      buf_data_q, buf_data_d;

    logic             drop, beat_ok, ms_ready_go, leave, stage_load, fwd_active;
    logic [31:0]      load_data, aligned;

    // A beat arriving while cancel_cnt > 0 belongs to a flushed instruction.
    assign drop        = dbus.data_ok && (cancel_q != '0);
    assign beat_ok     = dbus.data_ok && !drop;
    assign ms_ready_go = !req_sent_q || buf_valid_q || beat_ok;
    assign ms_allowin  = !ms_valid_q || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go && !flush;
    assign leave       = ms_to_ws_valid && ws_allowin;
    assign stage_load  = es_valid && ms_allowin && !flush;

    assign dbus.ms_can_issue = (pend_q < MAX_CNT);

    always_comb begin
        pend_d = pend_q + CNT_W'(dbus.es_req_fire) - CNT_W'(dbus.data_ok);

        // On flush every request still outstanding after this cycle's traffic
        // is owed a discarded beat; a same-cycle beat is already accounted for.
        cancel_d = cancel_q;
        if (flush) begin
            cancel_d = pend_d;
        end else if (drop) begin
            cancel_d = cancel_q - CNT_W'(1);
        end

        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        if (flush || leave) begin
            buf_valid_d = 1'b0;
        end else if (beat_ok && ms_valid_q && req_sent_q && !buf_valid_q) begin
            buf_valid_d = 1'b1;
            buf_data_d  = dbus.data_rdata;
        end

        ms_valid_d = ms_valid_q;
        if (flush) begin
            ms_valid_d = 1'b0;
        end else if (ms_allowin) begin
            ms_valid_d = es_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q  <= 1'b0;
            pend_q      <= '0;
            cancel_q    <= '0;
            buf_valid_q <= 1'b0;
            buf_data_q  <= '0;
            pc_q        <= '0;
            alu_q       <= '0;
            rt_q        <= '0;
            dest_q      <= '0;
            gr_we_q     <= '0;
            load_op_q   <= '0;
            ext_q       <= 1'b0;
            req_sent_q  <= 1'b0;
            ex_q        <= 1'b0;
            sb_q        <= '0;
        end else begin
            ms_valid_q  <= ms_valid_d;
            pend_q      <= pend_d;
            cancel_q    <= cancel_d;
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
            if (stage_load) begin
                pc_q       <= in_pc;
                alu_q      <= in_alu_result;
                rt_q       <= in_rt_value;
                dest_q     <= in_dest;
                gr_we_q    <= in_gr_we;
                load_op_q  <= in_load_op;
                ext_q      <= in_load_ext;
                req_sent_q <= in_req_sent;
                ex_q       <= in_ex;
                sb_q       <= in_sideband;
            end
        end
    end

    assert property (@(posedge clk) disable iff (reset) pend_q <= MAX_CNT);

    assign load_data = buf_valid_q ? buf_data_q : dbus.data_rdata;

    load_align u_load_align (
        .data_i    (load_data),
        .offset_i  (alu_q[1:0]),
        .load_op_i (load_op_q),
        .ext_i     (ext_q),
        .rt_i      (rt_q),
        .result_o  (aligned)
    );

    assign out_result   = is_load_op(load_op_q) ? aligned : alu_q;
    assign out_pc       = pc_q;
    assign out_dest     = dest_q;
    assign out_gr_we    = flush ? '0 : gr_we_q;
    assign out_ex       = ex_q;
    assign out_sideband = sb_q;
    assign ms_ex_block  = ms_valid_q && ex_q;

    assign fwd_active     = ms_valid_q && !flush;
    assign fwd_valid      = fwd_active;
    assign fwd_we         = fwd_active ? gr_we_q : '0;
    assign fwd_dest       = fwd_active ? dest_q : '0;
    assign fwd_result     = fwd_active ? out_result : '0;
    assign fwd_data_ready = fwd_active && ms_ready_go;

endmodule

// File: tb/tb_mem_resp_stage.sv
// Directed self-checking bench for mem_resp_stage (MAX_OUTST=2); lwl/lwr
// expectations follow MEM_LWLR_EN.
module tb_mem_resp_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, es_valid, ws_allowin;
  logic        ms_allowin, ms_to_ws_valid, out_ex, ms_ex_block;
  logic [31:0] in_pc, in_alu_result, in_rt_value;
  logic [4:0]  in_dest;
  logic [3:0]  in_gr_we;
  logic [2:0]  in_load_op;
  logic        in_load_ext, in_req_sent, in_ex;
  logic [63:0] in_sideband, out_sideband;
  logic [31:0] out_pc, out_result;
  logic [4:0]  out_dest;
  logic [3:0]  out_gr_we;
  logic        fwd_valid, fwd_data_ready;
  logic [3:0]  fwd_we;
  logic [4:0]  fwd_dest;
  logic [31:0] fwd_result;
  logic [31:0] exp_lwl, exp_lwr;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  mem_resp_stage_if dbus ();

  mem_resp_stage #(.MAX_OUTST(2), .SB_W(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .es_valid       (es_valid),
    .ms_allowin     (ms_allowin),
    .dbus           (dbus.slave),
    .in_pc          (in_pc),
    .in_alu_result  (in_alu_result),
    .in_rt_value    (in_rt_value),
    .in_dest        (in_dest),
    .in_gr_we       (in_gr_we),
    .in_load_op     (in_load_op),
    .in_load_ext    (in_load_ext),
    .in_req_sent    (in_req_sent),
    .in_ex          (in_ex),
    .in_sideband    (in_sideband),
    .ws_allowin     (ws_allowin),
    .ms_to_ws_valid (ms_to_ws_valid),
    .out_pc         (out_pc),
    .out_result     (out_result),
    .out_dest       (out_dest),
    .out_gr_we      (out_gr_we),
    .out_ex         (out_ex),
    .out_sideband   (out_sideband),
    .ms_ex_block    (ms_ex_block),
    .fwd_valid      (fwd_valid),
    .fwd_we         (fwd_we),
    .fwd_dest       (fwd_dest),
    .fwd_result     (fwd_result),
    .fwd_data_ready (fwd_data_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ex(input logic [2:0] op, input logic [31:0] alu,
                        input logic [4:0] dest, input logic rs, input logic ex);
    in_load_op    = op;
    in_alu_result = alu;
    in_pc         = alu + 32'h1000;
    in_dest       = dest;
    in_req_sent   = rs;
    in_ex         = ex;
    in_load_ext   = 1'b1;
    in_gr_we      = 4'hf;
  endtask

  initial begin
`ifdef MEM_LWLR_EN
    exp_lwl = 32'h2211_CCDD;
    exp_lwr = 32'hAABB_4433;
`else
    exp_lwl = 32'h4433_2211;
    exp_lwr = 32'h4433_2211;
`endif
    reset = 1'b1; flush = 1'b0; es_valid = 1'b0; ws_allowin = 1'b1;
    in_rt_value = 32'hAABB_CCDD; in_sideband = 64'h0123_4567_89AB_CDEF;
    set_ex(LOAD_OP_ALU, 32'h0, 5'd0, 1'b0, 1'b0);
    dbus.es_req_fire = 1'b0; dbus.data_ok = 1'b0; dbus.data_rdata = '0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_allowin", ms_allowin, 1'b1);
    check("rst_can_issue", dbus.ms_can_issue, 1'b1);
    check("rst_to_ws", ms_to_ws_valid, 1'b0);
    check("rst_fwd_valid", fwd_valid, 1'b0);
    check("rst_result", out_result, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    set_ex(LOAD_OP_LB, 32'h1003, 5'd5, 1'b1, 1'b0);
    es_valid = 1'b1; dbus.es_req_fire = 1'b1;
    @(negedge clk);
    es_valid = 1'b0; dbus.es_req_fire = 1'b0; #1;
    check("lb_wait_to_ws", ms_to_ws_valid, 1'b0);
    check("lb_wait_fwd_valid", fwd_valid, 1'b1);
    check("lb_wait_fwd_ready", fwd_data_ready, 1'b0);
    check("lb_wait_fwd_dest", fwd_dest, 5'd5);
    check("lb_wait_allowin", ms_allowin, 1'b0);
    dbus.data_ok = 1'b1; dbus.data_rdata = 32'h80FF_1234; #1;
    check("lb_to_ws", ms_to_ws_valid, 1'b1);
    check("lb_result", out_result, 32'hFFFF_FF80);
    check("lb_pc", out_pc, 32'h2003);
    check("lb_fwd_ready", fwd_data_ready, 1'b1);
    @(negedge clk);
    dbus.data_ok = 1'b0; #1;
    check("lb_gone", ms_to_ws_valid, 1'b0);

    set_ex(LOAD_OP_LH, 32'h2002, 5'd6, 1'b1, 1'b0);
    es_valid = 1'b1; dbus.es_req_fire = 1'b1;
    @(negedge clk);
    es_valid = 1'b0; dbus.es_req_fire = 1'b0; ws_allowin = 1'b0;
    dbus.data_ok = 1'b1; dbus.data_rdata = 32'h8001_0000; #1;
    check("lh_stall_allowin", ms_allowin, 1'b0);
    @(negedge clk);
    dbus.data_ok = 1'b0; dbus.data_rdata = 32'hDEAD_BEEF; #1;
    check("lh_buf_to_ws", ms_to_ws_valid, 1'b1);
    check("lh_buf_result", out_result, 32'hFFFF_8001);
    ws_allowin = 1'b1; #1;
    check("lh_release_allowin", ms_allowin, 1'b1);
    @(negedge clk); #1;
    check("lh_gone", ms_to_ws_valid, 1'b0);

    set_ex(LOAD_OP_LW, 32'h3000, 5'd7, 1'b1, 1'b0);
    es_valid = 1'b1; dbus.es_req_fire = 1'b1;
    @(negedge clk); #1;
    check("two_one_pending_can_issue", dbus.ms_can_issue, 1'b1);
    @(negedge clk);
    es_valid = 1'b0; dbus.es_req_fire = 1'b0; #1;
    check("two_full_can_issue", dbus.ms_can_issue, 1'b0);
    flush = 1'b1; #1;
    check("flush_to_ws", ms_to_ws_valid, 1'b0);
    check("flush_fwd_valid", fwd_valid, 1'b0);
    check("flush_gr_we", out_gr_we, 4'h0);
    @(negedge clk);
    flush = 1'b0; dbus.data_ok = 1'b1; dbus.data_rdata = 32'h1111_1111; #1;
    check("drop1_can_issue", dbus.ms_can_issue, 1'b0);
    @(negedge clk);
    dbus.data_rdata = 32'h2222_2222;
    set_ex(LOAD_OP_LW, 32'h4000, 5'd8, 1'b1, 1'b0);
    es_valid = 1'b1; dbus.es_req_fire = 1'b1; #1;
    check("drop2_can_issue", dbus.ms_can_issue, 1'b1);
    @(negedge clk);
    es_valid = 1'b0; dbus.es_req_fire = 1'b0; dbus.data_rdata = 32'h3333_3333; #1;
    check("third_to_ws", ms_to_ws_valid, 1'b1);
    check("third_result", out_result, 32'h3333_3333);
    check("third_dest", out_dest, 5'd8);
    @(negedge clk);
    dbus.data_ok = 1'b0;

    set_ex(LOAD_OP_LW, 32'h5000, 5'd9, 1'b1, 1'b0);
    es_valid = 1'b1; dbus.es_req_fire = 1'b1;
    @(negedge clk);
    @(negedge clk);
    es_valid = 1'b0; dbus.es_req_fire = 1'b0; #1;
    check("co_full_can_issue", dbus.ms_can_issue, 1'b0);
    flush = 1'b1; dbus.data_ok = 1'b1; dbus.data_rdata = 32'h5555_5555; #1;
    check("co_flush_to_ws", ms_to_ws_valid, 1'b0);
    @(negedge clk);
    flush = 1'b0; dbus.data_rdata = 32'h6666_6666;
    set_ex(LOAD_OP_LW, 32'h6000, 5'd10, 1'b1, 1'b0);
    es_valid = 1'b1; dbus.es_req_fire = 1'b1; #1;
    check("co_one_left_can_issue", dbus.ms_can_issue, 1'b1);
    @(negedge clk);
    es_valid = 1'b0; dbus.es_req_fire = 1'b0; dbus.data_rdata = 32'h7777_7777; #1;
    check("co_next_to_ws", ms_to_ws_valid, 1'b1);
    check("co_next_result", out_result, 32'h7777_7777);
    @(negedge clk);
    dbus.data_ok = 1'b0;

    set_ex(LOAD_OP_LWL, 32'h7001, 5'd11, 1'b1, 1'b0);
    es_valid = 1'b1; dbus.es_req_fire = 1'b1;
    @(negedge clk);
    es_valid = 1'b0; dbus.es_req_fire = 1'b0;
    dbus.data_ok = 1'b1; dbus.data_rdata = 32'h4433_2211; #1;
    check("lwl_result", out_result, exp_lwl);
    check("lwl_fwd_result", fwd_result, exp_lwl);
    @(negedge clk);
    dbus.data_ok = 1'b0;
    set_ex(LOAD_OP_LWR, 32'h7002, 5'd11, 1'b1, 1'b0);
    es_valid = 1'b1; dbus.es_req_fire = 1'b1;
    @(negedge clk);
    es_valid = 1'b0; dbus.es_req_fire = 1'b0;
    dbus.data_ok = 1'b1; dbus.data_rdata = 32'h4433_2211; #1;
    check("lwr_result", out_result, exp_lwr);
    @(negedge clk);
    dbus.data_ok = 1'b0;

    set_ex(LOAD_OP_ALU, 32'h1234_5678, 5'd3, 1'b0, 1'b0);
    es_valid = 1'b1;
    @(negedge clk);
    es_valid = 1'b0; ws_allowin = 1'b0; #1;
    check("alu_fwd_valid", fwd_valid, 1'b1);
    check("alu_fwd_ready", fwd_data_ready, 1'b1);
    check("alu_fwd_dest", fwd_dest, 5'd3);
    check("alu_fwd_we", fwd_we, 4'hf);
    check("alu_fwd_result", fwd_result, 32'h1234_5678);
    check("alu_to_ws", ms_to_ws_valid, 1'b1);
    check("alu_gr_we", out_gr_we, 4'hf);
    check("alu_sideband", out_sideband, 64'h0123_4567_89AB_CDEF);
    ws_allowin = 1'b1;
    @(negedge clk);

    set_ex(LOAD_OP_LW, 32'h8000, 5'd4, 1'b0, 1'b1);
    es_valid = 1'b1;
    @(negedge clk);
    es_valid = 1'b0; #1;
    check("ex_block", ms_ex_block, 1'b1);
    check("ex_to_ws", ms_to_ws_valid, 1'b1);
    check("ex_out_ex", out_ex, 1'b1);
    @(negedge clk); #1;
    check("ex_block_clear", ms_ex_block, 1'b0);

    set_ex(LOAD_OP_LW, 32'h9000, 5'd12, 1'b1, 1'b0);
    es_valid = 1'b1; dbus.es_req_fire = 1'b1;
    @(negedge clk);
    @(negedge clk);
    es_valid = 1'b0; dbus.es_req_fire = 1'b0; #1;
    check("pre_reset_can_issue", dbus.ms_can_issue, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; #1;
    check("post_reset_can_issue", dbus.ms_can_issue, 1'b1);
    check("post_reset_allowin", ms_allowin, 1'b1);
    check("post_reset_fwd_valid", fwd_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
